// File: rtl/fmul_arbiter.sv
// Round-robin front end that shares one fmul between N_REQ requesters, one op in flight at a time.
// Optional: define FMUL_ARB_ZERO_SHORTCUT_EN to resolve zero/denormal operands locally in one cycle.
module fmul_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [32*N_REQ-1:0]  req_x1,
    input  logic [32*N_REQ-1:0]  req_x2,
    output logic [N_REQ-1:0]     req_ready,
    output logic [N_REQ-1:0]     resp_valid,
    output logic [31:0]          resp_y,
    output logic [31:0]          fmul_x1,
    output logic [31:0]          fmul_x2,
    output logic                 fmul_ready,
    input  logic                 fmul_valid,
    input  logic [31:0]          fmul_y
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   gnt_q, gnt_d;
    logic [N_REQ-1:0]   resp_valid_q, resp_valid_d;
    logic [31:0]        resp_y_q, resp_y_d;
    logic [31:0]        x1_q, x1_d;
    logic [31:0]        x2_q, x2_d;

    logic [31:0]        x1_arr [N_REQ];
    logic [31:0]        x2_arr [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign x1_arr[gi] = req_x1[32*gi +: 32];
        assign x2_arr[gi] = req_x2[32*gi +: 32];
    end

    // Rotate requests so bit 0 is the requester at ptr, then take the lowest set bit.
    logic [N_REQ-1:0]   rot;
    logic [IDX_W-1:0]   sel_off;
    logic [IDX_W:0]     sel_sum;
    logic [IDX_W-1:0]   sel_idx;
    logic               sel_found;
    logic [N_REQ-1:0]   sel_oh;
    logic [31:0]        sel_x1;
    logic [31:0]        sel_x2;

    always_comb begin
        rot       = N_REQ'({req_valid, req_valid} >> ptr_q);
        sel_found = 1'b0;
        sel_off   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                sel_found = 1'b1;
                sel_off   = IDX_W'(k);
            end
        end
        sel_sum = {1'b0, ptr_q} + {1'b0, sel_off};
        if (sel_sum >= (IDX_W+1)'(N_REQ)) begin
            sel_idx = IDX_W'(sel_sum - (IDX_W+1)'(N_REQ));
        end else begin
            sel_idx = sel_sum[IDX_W-1:0];
        end
        sel_oh = N_REQ'(1) << sel_idx;
        sel_x1 = x1_arr[sel_idx];
        sel_x2 = x2_arr[sel_idx];
    end

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
        return (v == IDX_W'(N_REQ - 1)) ? '0 : v + IDX_W'(1);
    endfunction

`ifdef FMUL_ARB_ZERO_SHORTCUT_EN
    logic sel_zero;
    assign sel_zero = (sel_x1[30:23] == 8'd0) || (sel_x2[30:23] == 8'd0);
`endif

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        gnt_d        = gnt_q;
        x1_d         = x1_q;
        x2_d         = x2_q;
        resp_valid_d = '0;
        resp_y_d     = resp_y_q;
        req_ready    = '0;
        fmul_ready   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sel_found) begin
                    req_ready = sel_oh;
`ifdef FMUL_ARB_ZERO_SHORTCUT_EN
                    if (sel_zero) begin
                        // Signed zero is exactly what fmul returns for zero/denormal inputs.
                        resp_y_d     = {sel_x1[31] ^ sel_x2[31], 31'b0};
                        resp_valid_d = sel_oh;
                        ptr_d        = wrap_inc(sel_idx);
                    end else begin
                        x1_d    = sel_x1;
                        x2_d    = sel_x2;
                        gnt_d   = sel_idx;
                        state_d = S_ISSUE;
                    end
`else
                    x1_d    = sel_x1;
                    x2_d    = sel_x2;
                    gnt_d   = sel_idx;
                    state_d = S_ISSUE;
`endif
                end
            end
            S_ISSUE: begin
                fmul_ready = 1'b1;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (fmul_valid) begin
                    resp_y_d     = fmul_y;
                    resp_valid_d = N_REQ'(1) << gnt_q;
                    ptr_d        = wrap_inc(gnt_q);
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            gnt_q        <= '0;
            x1_q         <= '0;
            x2_q         <= '0;
            resp_valid_q <= '0;
            resp_y_q     <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            gnt_q        <= gnt_d;
            x1_q         <= x1_d;
            x2_q         <= x2_d;
            resp_valid_q <= resp_valid_d;
            resp_y_q     <= resp_y_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_y     = resp_y_q;
    assign fmul_x1    = x1_q;
    assign fmul_x2    = x2_q;

endmodule

// File: tb/tb_fmul_arbiter.sv
// Bench for fmul_arbiter: vector table, cycle scoreboard, behavioural fmul with adjustable latency.
module tb_fmul_arbiter;
    localparam int N = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [32*N-1:0]   req_x1 = '0;
    logic [32*N-1:0]   req_x2 = '0;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      resp_valid;
    logic [31:0]       resp_y;
    logic [31:0]       fmul_x1;
    logic [31:0]       fmul_x2;
    logic              fmul_ready;
    logic              fmul_valid;
    logic [31:0]       fmul_y = '0;
    logic              f_valid = 1'b0;
    logic              stray = 1'b0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int flat  = 1;

    always #5 clk = ~clk;
    assign fmul_valid = f_valid | stray;

    fmul_arbiter #(.N_REQ(N)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_x1(req_x1), .req_x2(req_x2),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_y(resp_y),
        .fmul_x1(fmul_x1), .fmul_x2(fmul_x2), .fmul_ready(fmul_ready),
        .fmul_valid(fmul_valid), .fmul_y(fmul_y)
    );

    typedef struct {
        logic [N-1:0] mask;
        logic [31:0]  x1;
        logic [31:0]  x2;
        int           g;
        logic [31:0]  y;
    } vec_t;

    typedef struct {
        int          g;
        logic [31:0] y;
        int          due;
    } exp_t;

    exp_t sb[$];

    // Reference products for the vectors used here; other operands get an arbitrary stand-in value.
    function automatic logic [31:0] fmul_ref(input logic [31:0] a, input logic [31:0] b);
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {a[31] ^ b[31], 31'b0};
        case ({a, b})
            64'h40000000_40400000: return 32'h40C00000;
            64'h3FC00000_3FC00000: return 32'h40100000;
            64'hBF800000_3F800000: return 32'hBF800000;
            default:               return {a[31] ^ b[31], a[30:0] ^ {b[15:0], b[30:16]}};
        endcase
    endfunction

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    function automatic logic is_zero_op(input logic [31:0] a, input logic [31:0] b);
        return (a[30:23] == 8'd0) || (b[30:23] == 8'd0);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc <= cyc + 1;
    end

    // Behavioural fmul: valid arrives flat cycles after the ready pulse.
    initial begin : fmul_model
        int f_cnt;
        f_cnt = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                f_cnt = 0;
                f_valid <= 1'b0;
            end else if (fmul_ready) begin
                if (flat == 1) begin
                    f_valid <= 1'b1;
                    fmul_y  <= fmul_ref(fmul_x1, fmul_x2);
                    f_cnt = 0;
                end else begin
                    f_valid <= 1'b0;
                    f_cnt = flat - 1;
                end
            end else if (f_cnt == 1) begin
                f_valid <= 1'b1;
                fmul_y  <= fmul_ref(fmul_x1, fmul_x2);
                f_cnt = 0;
            end else begin
                f_valid <= 1'b0;
                if (f_cnt > 1) f_cnt--;
            end
        end
    end

    // Cycle model: predicts grants, fmul_ready pulses and response timing/content.
    initial begin : monitor
        int   m_ptr, fr_due, g;
        logic m_idle;
        exp_t e;
        logic [31:0] a, b;
        m_ptr = 0; fr_due = -1; m_idle = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
                m_idle = 1'b1; m_ptr = 0; fr_due = -1;
            end else begin
                if (sb.size() > 0 && sb[0].due == cyc) begin
                    e = sb.pop_front();
                    chk("sb_resp_valid", 32'(resp_valid), 32'(1 << e.g));
                    chk("sb_resp_y", resp_y, e.y);
                    m_ptr  = (e.g + 1) % N;
                    m_idle = 1'b1;
                end else begin
                    chk("sb_resp_quiet", 32'(resp_valid), 32'd0);
                end
                chk("sb_fmul_ready", 32'(fmul_ready), 32'(cyc == fr_due));
                if (m_idle && req_valid != '0) begin
                    g = pick(req_valid, m_ptr);
                    chk("sb_req_ready", 32'(req_ready), 32'(1 << g));
                    a = req_x1[32*g +: 32];
                    b = req_x2[32*g +: 32];
                    e.g = g;
                    e.y = fmul_ref(a, b);
                    e.due = cyc + 2 + flat;
                    fr_due = cyc + 1;
`ifdef FMUL_ARB_ZERO_SHORTCUT_EN
                    if (is_zero_op(a, b)) begin
                        e.due  = cyc + 1;
                        fr_due = -1;
                    end
`endif
                    sb.push_back(e);
                    m_idle = 1'b0;
                end else begin
                    chk("sb_req_ready_quiet", 32'(req_ready), 32'd0);
                end
            end
        end
    end

    task automatic wait_ready(output logic [N-1:0] got, output int at);
        got = '0; at = -1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                got = req_ready; at = cyc;
                return;
            end
        end
        total++; bad++;
        $display("FAIL accept_timeout: got no req_ready want one within 30 cycles");
    endtask

    task automatic wait_resp(output logic [N-1:0] got, output logic [31:0] y, output int at);
        got = '0; y = '0; at = -1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (resp_valid != '0) begin
                got = resp_valid; y = resp_y; at = cyc;
                return;
            end
        end
        total++; bad++;
        $display("FAIL resp_timeout: got no resp_valid want one within 30 cycles");
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({nm, "_resp_valid"}, 32'(resp_valid), 32'd0);
        chk({nm, "_resp_y"}, resp_y, 32'd0);
        chk({nm, "_fmul_x1"}, fmul_x1, 32'd0);
        chk({nm, "_fmul_x2"}, fmul_x2, 32'd0);
        chk({nm, "_fmul_ready"}, 32'(fmul_ready), 32'd0);
    endtask

    task automatic drive_vec(input vec_t v);
        logic [N-1:0] got;
        logic [31:0]  y;
        int           t_acc, t_resp, lat;
        @(posedge clk); #1;
        for (int j = 0; j < N; j++) begin
            req_x1[32*j +: 32] = (j == v.g) ? v.x1 : 32'h41000000 + 32'(j);
            req_x2[32*j +: 32] = (j == v.g) ? v.x2 : 32'h40800000 + 32'(j);
        end
        req_valid = v.mask;
        wait_ready(got, t_acc);
        chk("tbl_grant", 32'(got), 32'(1 << v.g));
        @(posedge clk); #1;
        req_valid = '0;
        wait_resp(got, y, t_resp);
        chk("tbl_resp_valid", 32'(got), 32'(1 << v.g));
        chk("tbl_resp_y", y, v.y);
        lat = 2 + flat;
`ifdef FMUL_ARB_ZERO_SHORTCUT_EN
        if (is_zero_op(v.x1, v.x2)) lat = 1;
`endif
        chk("tbl_latency", 32'(t_resp - t_acc), 32'(lat));
        $display("op mask=%b grant=%b y=%h latency=%0d", v.mask, got, y, t_resp - t_acc);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got no finish want finish before 400000");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        vec_t tbl[6];
        logic [N-1:0] got;
        logic [31:0]  y;
        int t_acc, t_prev, t_resp;
        int rr_exp[5] = '{0, 1, 2, 3, 0};

        tbl[0] = '{4'b0001, 32'h40000000, 32'h40400000, 0, 32'h40C00000};
        tbl[1] = '{4'b0101, 32'hBF800000, 32'h3F800000, 2, 32'hBF800000};
        tbl[2] = '{4'b1010, 32'h3FC00000, 32'h3FC00000, 3, 32'h40100000};
        tbl[3] = '{4'b1010, 32'h40000000, 32'h40400000, 1, 32'h40C00000};
        tbl[4] = '{4'b0001, 32'h00000000, 32'hC0000000, 0, 32'h80000000};
        tbl[5] = '{4'b1000, 32'h00400000, 32'h3F800000, 3, 32'h00000000};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_zero("reset");

        for (int i = 0; i < 6; i++) drive_vec(tbl[i]);

        // All four requesting continuously: strict rotation, one accept every 3 cycles.
        @(posedge clk); #1;
        for (int j = 0; j < N; j++) begin
            req_x1[32*j +: 32] = 32'h3FC00000;
            req_x2[32*j +: 32] = 32'h3FC00000;
        end
        req_valid = '1;
        t_prev = 0;
        for (int k = 0; k < 5; k++) begin
            wait_ready(got, t_acc);
            chk("rr_grant", 32'(got), 32'(1 << rr_exp[k]));
            if (k > 0) chk("rr_spacing", 32'(t_acc - t_prev), 32'd3);
            $display("rr grant=%b cycle=%0d", got, t_acc);
            t_prev = t_acc;
        end
        @(posedge clk); #1;
        req_valid = '0;
        wait_resp(got, y, t_resp);
        chk("rr_last_y", y, 32'h40100000);

        // A stray fmul_valid while idle must not produce a response.
        @(posedge clk); #1 stray = 1'b1;
        @(posedge clk); #1 stray = 1'b0;
        repeat (3) @(posedge clk);

        flat = 3;
        drive_vec('{4'b0100, 32'h40000000, 32'h40400000, 2, 32'h40C00000});

        // Reset while waiting on fmul: op is dropped and the pointer returns to 0.
        flat = 6;
        @(posedge clk); #1;
        req_x1[32*3 +: 32] = 32'h3FC00000;
        req_x2[32*3 +: 32] = 32'h3FC00000;
        req_valid = 4'b1000;
        wait_ready(got, t_acc);
        chk("rstwait_grant", 32'(got), 32'b1000);
        @(posedge clk); #1 req_valid = '0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_zero("rst_in_wait");
        repeat (12) @(posedge clk);
        flat = 1;
        drive_vec('{4'b1001, 32'hBF800000, 32'h3F800000, 0, 32'hBF800000});

        repeat (4) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
